pipelined_adder: RTL and testbench

Parametrised, pipelined successor to the combinational full adder. Splits a WIDTH-bit add/subtract into CHUNK-bit slices, one slice per pipeline stage, with the carry registered between stages. Uses a valid/ready stream interface on both sides and a per-transaction add/subtract mode. Intended for wide datapath arithmetic where a single-cycle ripple path misses timing.

---
 rtl/pipelined_adder.sv | 127 ++++++++++++
 tb/tb_pipelined_adder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract split into CHUNK-bit slices, one
// slice per pipeline stage, carry registered between stages. Operand bits not
// yet summed and result bits already summed travel alongside each transaction,
// so the complete sum leaves the last stage aligned.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. valid does not wait for ready. While
// out_valid=1 && out_ready=0, sum/cout/ovf hold. The whole pipeline advances
// on one enable, en = out_ready || !out_valid. in_ready is that enable, so a
// stalled output freezes every stage and refuses new input.
//
// Timing: the accept cycle counts as cycle 0 and the result is valid in cycle
// STAGES. Stage 0 sums slice 0 straight from the inputs on the accept edge.
// Stage k registers slice k, and the last stage's registers are the outputs.
// WIDTH must be an integer multiple of CHUNK.
module pipelined_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    // Stage registers: valid, remaining operands (b already conditionally
    // inverted), partial sum and carry out of the slice handled by the stage.
    logic             v_q [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             ovf_q;

    // Values presented to each stage by the stage before it (or by the inputs).
    logic             v_src [STAGES];
    logic [WIDTH-1:0] a_src [STAGES];
    logic [WIDTH-1:0] b_src [STAGES];
    logic [WIDTH-1:0] s_src [STAGES];
    logic             c_src [STAGES];

    // Per-stage combinational results.
    logic [CHUNK:0]   slice [STAGES];
    logic [WIDTH-1:0] s_nxt [STAGES];
    logic             ovf_nxt;

    logic en;

    // Single global enable: the pipeline moves unless the output is stalled.
    assign en       = out_ready || !out_valid;
    assign in_ready = en;

    // Route the upstream input into stage 0 and each stage register into the next stage.
    always_comb begin
        v_src[0] = in_valid;
        a_src[0] = a;
        b_src[0] = sub ? ~b : b;
        s_src[0] = '0;
        c_src[0] = cin;
        for (int k = 1; k < STAGES; k++) begin
            v_src[k] = v_q[k-1];
            a_src[k] = a_q[k-1];
            b_src[k] = b_q[k-1];
            s_src[k] = s_q[k-1];
            c_src[k] = c_q[k-1];
        end
    end

    // Each stage sums its own slice and inserts it into the travelling partial sum.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            slice[k] = {1'b0, a_src[k][k*CHUNK +: CHUNK]}
                     + {1'b0, b_src[k][k*CHUNK +: CHUNK]}
                     + {{CHUNK{1'b0}}, c_src[k]};
            s_nxt[k] = s_src[k];
            s_nxt[k][k*CHUNK +: CHUNK] = slice[k][CHUNK-1:0];
        end
        // Carry into the MSB is recovered from the MSB's own sum bit.
        ovf_nxt = (a_src[LAST][WIDTH-1] ^ b_src[LAST][WIDTH-1] ^ s_nxt[LAST][WIDTH-1])
                ^ slice[LAST][CHUNK];
    end

    // Advance all stages together; data registers load only with a valid transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_src[k];
                if (v_src[k]) begin
                    a_q[k] <= a_src[k];
                    b_q[k] <= b_src[k];
                    s_q[k] <= s_nxt[k];
                    c_q[k] <= slice[k][CHUNK];
                end
            end
            if (v_src[LAST]) begin
                ovf_q <= ovf_nxt;
            end
        end
    end

    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder at WIDTH=8, CHUNK=4.
// A reference model computes {ovf,cout,sum} with plain integer arithmetic; a
// negedge monitor keeps the expected results in order in exp_q.
module tb_pipelined_adder;

    localparam int W      = 8;
    localparam int C      = 4;
    localparam int STAGES = W / C;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_checks = 0;
    int n_errors = 0;
    int n_pops   = 0;
    int run_len  = 0;
    int max_run  = 0;

    logic [W+1:0] exp_q[$];

    pipelined_adder #(.WIDTH(W), .CHUNK(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: {ovf, cout, sum} from two's-complement arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                           input logic tc, input logic ts);
        logic [W-1:0] bp;
        logic [W:0]   full;
        logic         o;
        bp   = ts ? ~tb : tb;
        full = {1'b0, ta} + {1'b0, bp} + {{W{1'b0}}, tc};
        o    = (ta[W-1] == bp[W-1]) && (full[W-1] != ta[W-1]);
        return {o, full};
    endfunction

    // Scoreboard: transfers seen at negedge take effect on the following posedge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            run_len = 0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", exp_q.size(), 1);
                end else begin
                    check(out_ready ? "result" : "held_result", {ovf, cout, sum}, exp_q[0]);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        n_pops++;
                    end
                end
            end
            if (out_valid && out_ready) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accept edge, in_valid left high.
    task automatic drive(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tc, input logic ts);
        int g;
        a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
        g = 0;
        @(negedge clk);
        while (!in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) check("accept_timeout", in_ready, 1);
        @(posedge clk); #1;
    endtask

    // Counts cycles after the accept edge until out_valid (bounded).
    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 50);
    endtask

    task automatic drain(input string tag);
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        check(tag, exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [W-1:0] ta;
        logic [W-1:0] tb;
        logic         tc;
        logic         ts;
        logic [W+1:0] res;   // {ovf, cout, sum}
    } vec_t;

    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int pops0;
        vec_t v;

        vecs[0] = '{8'h00, 8'h00, 1'b0, 1'b0, {1'b0, 1'b0, 8'h00}};
        vecs[1] = '{8'hFF, 8'hFF, 1'b1, 1'b0, {1'b0, 1'b1, 8'hFF}};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, {1'b1, 1'b0, 8'h80}};
        vecs[3] = '{8'h05, 8'h07, 1'b1, 1'b1, {1'b0, 1'b0, 8'hFE}};
        vecs[4] = '{8'h80, 8'h01, 1'b1, 1'b1, {1'b1, 1'b1, 8'h7F}};

        // reset
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // directed vectors with latency
        foreach (vecs[i]) begin
            v = vecs[i];
            drive(v.ta, v.tb, v.tc, v.ts);
            in_valid = 1'b0;
            wait_out(lat);
            check($sformatf("latency_%0d", i), lat, STAGES);
            check($sformatf("vec_%0d", i), {ovf, cout, sum}, v.res);
            @(posedge clk); #1;
        end

        // 10 back-to-back random transactions
        max_run = 0;
        pops0 = n_pops;
        for (int i = 0; i < 10; i++) begin
            drive(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        in_valid = 1'b0;
        drain("stream_drain");
        check("stream_count", n_pops - pops0, 10);
        check("stream_consecutive", max_run, 10);

        // stall with a full pipeline
        pops0 = n_pops;
        out_ready = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            drive(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain("stall_drain");
        check("stall_count", n_pops - pops0, STAGES + 1);

        // reset with transactions in flight
        drive(W'($urandom), W'($urandom), 1'b0, 1'b0);
        drive(W'($urandom), W'($urandom), 1'b0, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("flush_out_valid", out_valid, 0);
        end
        @(posedge clk); #1;
        drive(8'h01, 8'h02, 1'b0, 1'b0);
        in_valid = 1'b0;
        wait_out(lat);
        check("post_rst_latency", lat, STAGES);
        check("post_rst_result", {ovf, cout, sum}, {1'b0, 1'b0, 8'h03});
        @(posedge clk); #1;
        drain("final_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
